layer0_mac_ctrl_act: RTL and testbench
======================================

Name: layer0_mac_ctrl_act

Overview:
Control-and-activation helper for the first layer of the fixed-point neural network.
- It counts per-input MAC completion pulses and raises a sticky "all inputs accumulated" flag, ack_mac. That flag gates the layer's MAC request and starts the bias-add stage.
- It also holds the two neurons' activation functions. Neuron 0 uses a hard sigmoid; neuron 1 uses a ReLU. Both work on signed Q4.4 (8-bit) values.
- It sits between the layer's MAC/add datapath and its output registers.

Parameters:
- N_INPUTS, default 2: number of MAC ack pulses per inference (layer fan-in); range 1..255.
- WIDTH, default 8: data width of z/a values, signed two's complement, 4 fractional bits.
- CNT_W, default 8: width of the internal ack counter; must satisfy 2^CNT_W > N_INPUTS.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- ack  input  1  one-cycle pulse from the MAC unit: one input-weight product accumulated.
- ack_mac  output  1  sticky completion flag: N_INPUTS acks received.
- count  output  CNT_W  number of acks received since reset, saturating at N_INPUTS.
- z_value0  input  WIDTH  pre-activation of neuron 0, signed Q4.4.
- a0  output  WIDTH  activation of neuron 0 (hard sigmoid), signed Q4.4.
- z_value1  input  WIDTH  pre-activation of neuron 1, signed Q4.4.
- a1  output  WIDTH  activation of neuron 1 (ReLU), signed Q4.4.

Behaviour:
- Reset (rst=0, asynchronous): count=0 and ack_mac=0 immediately, with no clock edge required. Both remain held while rst=0. Release of rst is synchronised externally.
- Counter, on each rising clk edge with rst=1:
  - If ack=1 and count<N_INPUTS: count <= count+1.
  - If ack=1 and count==N_INPUTS-1: ack_mac <= 1 on the same edge, so ack_mac is high the cycle after the N-th ack (1-cycle latency).
  - ack_mac stays 1 until the next reset. It is not a pulse.
  - Once count==N_INPUTS, further acks are ignored: no wrap and no overflow.
  - ack=0 leaves state unchanged.
  - Back-to-back ack pulses (ack held high for k cycles) count as k acks.
- Reset mid-count (rst=0 while 0<count<N_INPUTS): counter clears asynchronously, and the partial count is discarded.
- ack_mac is a registered output with no combinational path from ack.
- func0 (a0), purely combinational, zero latency, hard sigmoid clamp(z/4 + 0.5, 0, 1) in Q4.4:
  - t = (z_value0 >>> 2) + 8, using an arithmetic shift (floor toward −inf) and computed at WIDTH+2 bits to avoid overflow.
  - a0 = 0 if t<0; 16 if t>16; else t.
  - Output range is 0..16 (0.0..1.0).
- func1 (a1), purely combinational, zero latency, ReLU:
  - a1 = 0 if z_value1 < 0, else z_value1.
  - −128 maps to 0; +127 maps to 127.
- The activation outputs do not depend on clk or rst.

Test Plan:
- Reset/count: assert rst=0 mid-cycle → count=0 and ack_mac=0 immediately, with no clock edge. Release, then pulse ack twice (N_INPUTS=2) on separate cycles → count=1 then 2; ack_mac=1 from the cycle after the second ack and stays 1 for 10 idle cycles.
- Saturation/back-to-back: hold ack=1 for 5 cycles → count sequence 1,2,2,2,2; ack_mac rises after cycle 2 and never deasserts.
- Mid-operation reset: one ack (count=1), then rst=0 for one cycle, then two acks → ack_mac rises only after the second post-reset ack.
- func0 sweep:
  - z=0 → 8.
  - z=32 → 16.
  - z=-32 → 0.
  - z=16 → 12.
  - z=-16 → 4.
  - z=-1 → 7 (floor).
  - z=127 → 16.
  - z=-128 → 0.
- func1 sweep:
  - z=0 → 0.
  - z=5 → 5.
  - z=127 → 127.
  - z=-1 → 0.
  - z=-128 → 0.
- Independence: drive z inputs while rst=0 and with clk stopped → a0/a1 still follow z combinationally.

Source files
------------

// File: rtl/layer0_mac_ctrl_act.sv
// Layer-0 MAC completion counter with sticky ack_mac flag, plus the two
// neuron activations: hard sigmoid (neuron 0) and ReLU (neuron 1), signed Q4.4.
module layer0_mac_ctrl_act #(
  parameter int N_INPUTS = 2,
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ack,
  output logic                    ack_mac,
  output logic [CNT_W-1:0]        count,
  input  logic signed [WIDTH-1:0] z_value0,
  output logic signed [WIDTH-1:0] a0,
  input  logic signed [WIDTH-1:0] z_value1,
  output logic signed [WIDTH-1:0] a1
);

  localparam logic [CNT_W-1:0]        LP_N    = CNT_W'(N_INPUTS);
  localparam logic [CNT_W-1:0]        LP_LAST = CNT_W'(N_INPUTS - 1);
  localparam logic [CNT_W-1:0]        LP_ONE  = CNT_W'(1);
  localparam logic signed [WIDTH+1:0] LP_HALF = (WIDTH+2)'(8);
  localparam logic signed [WIDTH+1:0] LP_SAT  = (WIDTH+2)'(16);

  logic [CNT_W-1:0]        r_count;
  logic                    r_ack_mac;
  logic signed [WIDTH+1:0] w_z0_ext;
  logic signed [WIDTH+1:0] w_t;
  logic signed [WIDTH-1:0] w_a0;
  logic signed [WIDTH-1:0] w_a1;

  // Ack counter saturating at N_INPUTS; ack_mac latches on the N-th ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count   <= '0;
      r_ack_mac <= 1'b0;
    end else if (ack && (r_count < LP_N)) begin
      r_count <= r_count + LP_ONE;
      if (r_count == LP_LAST) begin
        r_ack_mac <= 1'b1;
      end else begin
        r_ack_mac <= r_ack_mac;
      end
    end else begin
      r_count   <= r_count;
      r_ack_mac <= r_ack_mac;
    end
  end

  // Hard sigmoid: widened by two bits so z/4 + 0.5 cannot overflow before clamping
  always_comb begin
    w_z0_ext = {{2{z_value0[WIDTH-1]}}, z_value0};
    w_t      = (w_z0_ext >>> 2) + LP_HALF;
    w_a0     = '0;
    if (w_t[WIDTH+1]) begin
      w_a0 = '0;
    end else if (w_t > LP_SAT) begin
      w_a0 = WIDTH'(16);
    end else begin
      w_a0 = w_t[WIDTH-1:0];
    end
  end

  // ReLU
  always_comb begin
    w_a1 = '0;
    if (z_value1[WIDTH-1]) begin
      w_a1 = '0;
    end else begin
      w_a1 = z_value1;
    end
  end

  assign count   = r_count;
  assign ack_mac = r_ack_mac;
  assign a0      = w_a0;
  assign a1      = w_a1;

endmodule

// File: tb/tb_layer0_mac_ctrl_act.sv
// Scoreboard bench for layer0_mac_ctrl_act: expectations are queued as stimulus
// is driven and popped against the DUT outputs once they are due.
module tb_layer0_mac_ctrl_act;

  logic              clk;
  logic              clk_en;
  logic              rst;
  logic              ack;
  logic              ack_mac;
  logic [7:0]        count;
  logic signed [7:0] z_value0;
  logic signed [7:0] a0;
  logic signed [7:0] z_value1;
  logic signed [7:0] a1;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;

  exp_t q_exp[$];
  int   n_cmp;
  int   n_err;

  layer0_mac_ctrl_act #(.N_INPUTS(2), .WIDTH(8), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .ack      (ack),
    .ack_mac  (ack_mac),
    .count    (count),
    .z_value0 (z_value0),
    .a0       (a0),
    .z_value1 (z_value1),
    .a1       (a1)
  );

  // Gated clock so the combinational paths can be checked with no edges
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int get_obs(input int sel);
    case (sel)
      0:       get_obs = int'(count);
      1:       get_obs = int'(ack_mac);
      2:       get_obs = int'(a0);
      default: get_obs = int'(a1);
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sel, input int exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    q_exp.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      check_val(e.tag, get_obs(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ctr(input string tag, input int c, input int m);
    push_exp({tag, "_count"}, 0, c);
    push_exp({tag, "_ack_mac"}, 1, m);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // Activation sweep tables: z and expected outputs
  int f0_z[8] = '{0, 32, -32, 16, -16, -1, 127, -128};
  int f0_e[8] = '{8, 16, 0, 12, 4, 7, 16, 0};
  int f1_z[5] = '{0, 5, 127, -1, -128};
  int f1_e[5] = '{0, 5, 127, 0, 0};

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    clk      = 1'b0;
    clk_en   = 1'b1;
    rst      = 1'b0;
    ack      = 1'b0;
    z_value0 = 8'sd0;
    z_value1 = 8'sd0;

    tick();
    push_ctr("reset", 0, 0);
    drain();
    rst = 1'b1;
    tick();

    // Asynchronous reset mid-cycle after a partial count
    ack = 1'b1;
    tick();
    ack = 1'b0;
    push_ctr("pre_async", 1, 0);
    drain();
    #2;
    rst = 1'b0;
    #1;
    push_ctr("async_rst", 0, 0);
    drain();
    tick();
    rst = 1'b1;

    // Two separated acks
    ack = 1'b1;
    tick();
    ack = 1'b0;
    push_ctr("ack1", 1, 0);
    drain();
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    push_ctr("ack2", 2, 1);
    drain();
    for (int i = 0; i < 10; i++) begin
      tick();
      push_ctr("idle_sticky", 2, 1);
      drain();
    end

    // Back-to-back acks and saturation
    do_reset();
    push_ctr("sat_rst", 0, 0);
    drain();
    ack = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      push_ctr("sat", (i < 2) ? i : 2, (i >= 2) ? 1 : 0);
      drain();
    end
    ack = 1'b0;
    tick();
    push_ctr("sat_after", 2, 1);
    drain();

    // Reset in the middle of a count discards the partial count
    do_reset();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    push_ctr("mid_one", 1, 0);
    drain();
    do_reset();
    push_ctr("mid_rst", 0, 0);
    drain();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    push_ctr("mid_ack1", 1, 0);
    drain();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    push_ctr("mid_ack2", 2, 1);
    drain();

    // Activation sweeps
    for (int i = 0; i < 8; i++) begin
      z_value0 = 8'(f0_z[i]);
      push_exp($sformatf("a0_z%0d", f0_z[i]), 2, f0_e[i]);
      #1;
      drain();
    end
    for (int i = 0; i < 5; i++) begin
      z_value1 = 8'(f1_z[i]);
      push_exp($sformatf("a1_z%0d", f1_z[i]), 3, f1_e[i]);
      #1;
      drain();
    end

    // Activations follow z with reset asserted and the clock stopped
    clk_en = 1'b0;
    rst    = 1'b0;
    #3;
    for (int i = 0; i < 5; i++) begin
      z_value0 = 8'(f0_z[i + 3]);
      z_value1 = 8'(f1_z[4 - i]);
      push_exp("indep_a0", 2, f0_e[i + 3]);
      push_exp("indep_a1", 3, f1_e[4 - i]);
      #1;
      drain();
    end
    push_ctr("indep_ctr", 0, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
